// File: rtl/stdcell_drv_pkg.sv
// Shared types and sizing helpers for the standard-cell exhaustive driver.
package stdcell_drv_pkg;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Default configuration: a 3-input cell with a single settle cycle.
  localparam int DEF_NUM_INPUTS    = 3;
  localparam int DEF_SETTLE_CYCLES = 1;

  // Width of a counter that must hold the values 0..settle_cycles.
  function automatic int settle_cnt_w(input int settle_cycles);
    return $clog2(settle_cycles + 1);
  endfunction

  localparam int NUM_VECS = 1 << DEF_NUM_INPUTS;
  localparam int CNT_W    = settle_cnt_w(DEF_SETTLE_CYCLES);

endpackage

// File: rtl/stdcell_settle_timer.sv
// Loadable down-counter that tells the sequencer when a vector has settled.
module stdcell_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;

  // Load takes priority over decrement; a sync reset clears the count.
  always_ff @(posedge clk) begin
    // NOTE: registers are always written with <= so every flop samples
    // pre-edge values, independent of block evaluation order.
    if (reset)
      count_q <= '0;
    else if (load)
      count_q <= load_val;
    else if (dec && (count_q != '0))
      count_q <= count_q - W'(1);
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/stdcell_exhaustive_driver.sv
// Drives every input combination onto a combinational cell, waits for it to
// settle, compares Y against a truth table and records the sweep result.
module stdcell_exhaustive_driver
  import stdcell_drv_pkg::*;
#(
  parameter int                           NUM_INPUTS    = DEF_NUM_INPUTS,
  parameter int                           SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter logic [(1<<NUM_INPUTS)-1:0]   TRUTH_TABLE   = 8'h15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [NUM_INPUTS-1:0] dut_in,
  input  logic                  dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [NUM_INPUTS:0]   err_count,
  output logic [NUM_INPUTS-1:0] first_err_vec
);

  localparam int                    TMR_W    = settle_cnt_w(SETTLE_CYCLES);
  localparam logic [TMR_W-1:0]      RELOAD   = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [NUM_INPUTS-1:0] LAST_VEC = '1;
  localparam logic [NUM_INPUTS-1:0] VEC_ONE  = 1;
  localparam logic [NUM_INPUTS:0]   ERR_ONE  = 1;

  state_t state;
  logic   tmr_load;
  logic   tmr_dec;
  logic   tmr_zero;
  logic   mismatch;

  stdcell_settle_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (RELOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Timer control and the per-vector compare; X/Z on Y counts as a mismatch.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    mismatch = (dut_out !== TRUTH_TABLE[dut_in]);
    case (state)
      IDLE, DONE: tmr_load = start;
      SETTLE:     tmr_dec  = !tmr_zero;
      CHECK:      tmr_load = (dut_in != LAST_VEC);
      default:    tmr_load = 1'b0;
    endcase
  end

  // Sweep sequencer and scoreboard; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dut_in        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_vec <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= SETTLE;
            dut_in        <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vec <= '0;
          end
        end
        SETTLE: begin
          if (tmr_zero)
            state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + ERR_ONE;
            if (err_count == '0)
              first_err_vec <= dut_in;
          end
          if (dut_in != LAST_VEC) begin
            dut_in <= dut_in + VEC_ONE;
            state  <= SETTLE;
          end else begin
            // Sweep ends on all-ones; dut_in holds there while in DONE.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stdcell_exhaustive_driver.sv
// Directed bench: two drivers (settle 1 and settle 3) sweeping an AOI21
// gate model with selectable injected faults.
module tb_stdcell_exhaustive_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start3;
  logic [2:0] dut_in1, dut_in3;
  logic       dut_out1, dut_out3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [3:0] err1, err3;
  logic [2:0] first1, first3;

  int fault_mode = 0;  // 0 good, 1 Y stuck-0, 2 Y inverted at 3'b110
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // AOI21X1: Y = ~((A & B) | C), A = bit 2, B = bit 1, C = bit 0.
  function automatic logic cell_model(input logic [2:0] v, input int mode);
    logic y;
    y = ~((v[2] & v[1]) | v[0]);
    if (mode == 1) y = 1'b0;
    if (mode == 2 && v == 3'b110) y = ~y;
    return y;
  endfunction

  always_comb dut_out1 = cell_model(dut_in1, fault_mode);
  always_comb dut_out3 = cell_model(dut_in3, fault_mode);

  stdcell_exhaustive_driver #(
    .NUM_INPUTS(3), .SETTLE_CYCLES(1), .TRUTH_TABLE(8'h15)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .dut_in(dut_in1),
    .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_vec(first1)
  );

  stdcell_exhaustive_driver #(
    .NUM_INPUTS(3), .SETTLE_CYCLES(3), .TRUTH_TABLE(8'h15)
  ) dut3 (
    .clk(clk), .reset(reset), .start(start3), .dut_in(dut_in3),
    .dut_out(dut_out3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_err_vec(first3)
  );

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++;
    if ({dut_in1, busy1, done1, pass1, err1, first1} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_state1: got %b expected all zero",
               {dut_in1, busy1, done1, pass1, err1, first1});
    end
    n_cmp++;
    if ({dut_in3, busy3, done3, pass3, err3, first3} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_state3: got %b expected all zero",
               {dut_in3, busy3, done3, pass3, err3, first3});
    end
  endtask

  // Full settle-1 sweep started from IDLE or DONE; optional start re-pulses
  // at offsets 4 and 8 must be ignored.
  task automatic test_sweep(input string name, input int mode,
                            input logic [3:0] exp_err, input logic [2:0] exp_first,
                            input logic exp_pass, input bit repulse);
    fault_mode = mode;
    start1 = 1'b1;
    tick();                       // edge k accepts start
    start1 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (dut_in1 !== 3'(j >> 1) || busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_seq k+%0d: dut_in=%b busy=%b done=%b expected dut_in=%b busy=1 done=0",
                 name, j, dut_in1, busy1, done1, 3'(j >> 1));
      end
      start1 = repulse && (j == 3 || j == 7);
      tick();
    end
    start1 = 1'b0;
    n_cmp++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || dut_in1 !== 3'b111) begin
      n_bad++;
      $display("FAIL %s_done_k+16: done=%b busy=%b dut_in=%b expected 1 0 111",
               name, done1, busy1, dut_in1);
    end
    n_cmp++;
    if (pass1 !== exp_pass || err1 !== exp_err) begin
      n_bad++;
      $display("FAIL %s_result: pass=%b err=%0d expected pass=%b err=%0d",
               name, pass1, err1, exp_pass, exp_err);
    end
    if (exp_err != 4'd0) begin
      n_cmp++;
      if (first1 !== exp_first) begin
        n_bad++;
        $display("FAIL %s_first_err: got %b expected %b", name, first1, exp_first);
      end
    end
  endtask

  // Start while in DONE clears results on the next edge, then run to end.
  task automatic test_restart_from_done();
    fault_mode = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n_cmp++;
    if (err1 !== 4'd0 || done1 !== 1'b0 || pass1 !== 1'b0 || busy1 !== 1'b1 ||
        dut_in1 !== 3'd0 || first1 !== 3'd0) begin
      n_bad++;
      $display("FAIL restart_clear: err=%0d done=%b pass=%b busy=%b dut_in=%b first=%b expected 0 0 0 1 000 000",
               err1, done1, pass1, busy1, dut_in1, first1);
    end
    for (int j = 0; j < 16; j++) tick();
    n_cmp++;
    if (done1 !== 1'b1 || pass1 !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_end: done=%b pass=%b expected 1 1", done1, pass1);
    end
  endtask

  task automatic test_reset_mid_sweep();
    fault_mode = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || dut_in1 !== 3'd0 || err1 !== 4'd0) begin
      n_bad++;
      $display("FAIL mid_reset: busy=%b done=%b dut_in=%b err=%0d expected 0 0 000 0",
               busy1, done1, dut_in1, err1);
    end
    tick();
    test_sweep("after_reset", 0, 4'd0, 3'd0, 1'b1, 1'b0);
  endtask

  // Settle-3 instance: each vector held 4 cycles, done 32 cycles after start.
  task automatic test_settle3(input string name, input int mode,
                              input logic [3:0] exp_err, input logic exp_pass);
    fault_mode = mode;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int j = 0; j < 32; j++) begin
      n_cmp++;
      if (dut_in3 !== 3'(j >> 2) || done3 !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_seq k+%0d: dut_in=%b done=%b expected dut_in=%b done=0",
                 name, j, dut_in3, done3, 3'(j >> 2));
      end
      tick();
    end
    n_cmp++;
    if (done3 !== 1'b1 || pass3 !== exp_pass || err3 !== exp_err) begin
      n_bad++;
      $display("FAIL %s_done_k+32: done=%b pass=%b err=%0d expected 1 %b %0d",
               name, done3, pass3, err3, exp_pass, exp_err);
    end
  endtask

  task automatic test_settle3_restart();
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n_cmp++;
    if (err3 !== 4'd0 || done3 !== 1'b0 || busy3 !== 1'b1 || dut_in3 !== 3'd0) begin
      n_bad++;
      $display("FAIL settle3_restart: err=%0d done=%b busy=%b dut_in=%b expected 0 0 1 000",
               err3, done3, busy3, dut_in3);
    end
  endtask

  initial begin
    reset = 1'b0; start1 = 1'b0; start3 = 1'b0;
    test_reset();
    tick();
    test_sweep("good", 0, 4'd0, 3'd0, 1'b1, 1'b0);
    // Stuck-0 misses the three vectors where AOI21 gives Y=1 (000, 010, 100).
    test_sweep("stuck0", 1, 4'd3, 3'b000, 1'b0, 1'b0);
    test_restart_from_done();
    test_sweep("inv110", 2, 4'd1, 3'b110, 1'b0, 1'b0);
    test_sweep("repulse", 0, 4'd0, 3'd0, 1'b1, 1'b1);
    test_reset_mid_sweep();
    test_settle3("settle3_good", 0, 4'd0, 1'b1);
    test_settle3("settle3_stuck0", 1, 4'd3, 1'b0);
    test_settle3_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
